// File: rtl/tlc_pkg.sv
// Shared constants, command codes and state encoding for the TLC3548 emulator.
package tlc_pkg;

    localparam int FRAME_W = 16;  // bits per serial frame
    localparam int DATA_W  = 14;  // conversion result width
    localparam int CFR_W   = 12;  // configuration register width
    localparam int CH_W    = 3;   // channel number width
    localparam int SAMP_W  = 11;  // sample counter width

    localparam logic [3:0] CMD_RD_CFR = 4'h9;
    localparam logic [3:0] CMD_WR_CFR = 4'hA;

    // CONV is not a frame state of its own: a conversion runs alongside the
    // frame FSM and is tracked by busy plus the conversion counter.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        DECODE = 2'd2,
        CONV   = 2'd3
    } state_t;

    // Commands 0x0-0x7 select a channel and start a conversion.
    function automatic logic is_select(input logic [3:0] cmd);
        return (cmd[3] == 1'b0);
    endfunction

endpackage

// File: rtl/tlc3548_emu_if.sv
// Host-side serial bus of the TLC3548 emulator, plus its status outputs.
interface tlc3548_emu_if;
    import tlc_pkg::*;

    logic             cs_l;
    logic             fs;
    logic             sclk;
    logic             sdi;
    logic             cstart;
    logic             sdo;
    logic             int_l;
    logic             busy;
    logic [CFR_W-1:0] cfr;

    // Host (ADC controller) view.
    modport master (
        output cs_l, fs, sclk, sdi, cstart,
        input  sdo, int_l, busy, cfr
    );

    // Emulator view.
    modport slave (
        input  cs_l, fs, sclk, sdi, cstart,
        output sdo, int_l, busy, cfr
    );

endinterface

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous input, with single-clk rise and
// fall pulses derived from the synchronized value.
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [1:0] sync;
    logic       prev;

    // Resample the input and remember the previous synchronized level.
    // NOTE: state flops use non-blocking assignments so every stage samples the pre-edge value of the one before it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync <= 2'b00;
            prev <= 1'b0;
        end else begin
            sync <= {sync[0], d};
            prev <= sync[1];
        end
    end

    assign q    = sync[1];
    assign rise =  sync[1] & ~prev;
    assign fall = ~sync[1] &  prev;

endmodule

// File: rtl/tlc3548_emu.sv
// TLC3548 serial ADC emulator: 16-bit command/data frames over a host-clocked
// serial link, plus a timed conversion that produces a synthetic sample word
// of {channel, sample counter}.
module tlc3548_emu
    import tlc_pkg::*;
#(
    parameter int CONV_CLKS = 40  // clk cycles per conversion, 4..255
) (
    input  logic                clk,
    input  logic                rst,
    tlc3548_emu_if.slave        bus
);

    localparam int IN_CS     = 0;
    localparam int IN_FS     = 1;
    localparam int IN_SCLK   = 2;
    localparam int IN_SDI    = 3;
    localparam int IN_CSTART = 4;
    localparam int N_IN      = 5;

    // ------------------------------------------------------------------
    // Input synchronization
    // ------------------------------------------------------------------
    logic [N_IN-1:0] in_raw;
    logic [N_IN-1:0] in_q;
    logic [N_IN-1:0] in_rise;
    logic [N_IN-1:0] in_fall;

    assign in_raw = {bus.cstart, bus.sdi, bus.sclk, bus.fs, bus.cs_l};

    for (genvar i = 0; i < N_IN; i++) begin : g_sync
        sync_edge u_sync (
            .clk  (clk),
            .rst  (rst),
            .d    (in_raw[i]),
            .q    (in_q[i]),
            .rise (in_rise[i]),
            .fall (in_fall[i])
        );
    end

    logic cs_q, fs_q, sdi_q, sclk_rise, sclk_fall, cstart_fall;

    assign cs_q        = in_q[IN_CS];
    assign fs_q        = in_q[IN_FS];
    assign sdi_q       = in_q[IN_SDI];
    assign sclk_rise   = in_rise[IN_SCLK];
    assign sclk_fall   = in_fall[IN_SCLK];
    assign cstart_fall = in_fall[IN_CSTART];

    // Synchronizer outputs this block has no use for.
    logic unused_sync;
    assign unused_sync = ^{in_q[IN_SCLK], in_q[IN_CSTART],
                           in_rise[IN_CS], in_rise[IN_FS], in_rise[IN_SDI],
                           in_rise[IN_CSTART], in_fall[IN_CS], in_fall[IN_FS],
                           in_fall[IN_SDI]};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t              state;
    logic [FRAME_W-1:0]  tx_reg;
    logic [FRAME_W-1:0]  rx_reg;
    logic [3:0]          bit_cnt;
    logic                sdo;
    logic                int_l;
    logic                busy;
    logic [CFR_W-1:0]    cfr;
    logic [DATA_W-1:0]   result;
    logic [SAMP_W-1:0]   samp_cnt;
    logic [CH_W-1:0]     channel;
    logic [CH_W-1:0]     conv_ch;
    logic [7:0]          conv_cnt;
    logic                rd_cfr_pend;
    logic                done_pend;

    // ------------------------------------------------------------------
    // Frame/conversion control terms
    // ------------------------------------------------------------------
    logic               frame_start;
    logic               sel_decode;
    logic               start_conv;
    logic [CH_W-1:0]    conv_ch_next;
    logic [FRAME_W-1:0] load_word;
    logic [3:0]         cmd;

    // Combinational frame-start, decode and next-frame load terms.
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    always_comb begin
        cmd          = rx_reg[FRAME_W-1 -: 4];
        frame_start  = sclk_fall & ~cs_q & fs_q;
        sel_decode   = 1'b0;
        if (state == DECODE) begin
            sel_decode = is_select(cmd);
        end
        // A select decode and a cstart edge in the same clk give one start.
        start_conv   = ~busy & (sel_decode | cstart_fall);
        conv_ch_next = sel_decode ? cmd[CH_W-1:0] : channel;
        load_word    = rd_cfr_pend ? {4'h0, cfr} : {result, 2'b00};
    end

    // Frame FSM and conversion timer share one register block.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            tx_reg      <= '0;
            rx_reg      <= '0;
            bit_cnt     <= '0;
            sdo         <= 1'b0;
            int_l       <= 1'b1;
            busy        <= 1'b0;
            cfr         <= '0;
            result      <= '0;
            samp_cnt    <= '0;
            channel     <= '0;
            conv_ch     <= '0;
            conv_cnt    <= '0;
            rd_cfr_pend <= 1'b0;
            done_pend   <= 1'b0;
        end else begin
            // ---- serial frame ----
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        state       <= SHIFT;
                        sdo         <= load_word[FRAME_W-1];
                        tx_reg      <= {load_word[FRAME_W-2:0], 1'b0};
                        bit_cnt     <= '0;
                        int_l       <= 1'b1;
                        rd_cfr_pend <= 1'b0;
                    end
                end

                SHIFT: begin
                    if (cs_q) begin
                        // Aborted frame: received bits are simply dropped.
                        state <= IDLE;
                    end else if (frame_start) begin
                        sdo         <= load_word[FRAME_W-1];
                        tx_reg      <= {load_word[FRAME_W-2:0], 1'b0};
                        bit_cnt     <= '0;
                        int_l       <= 1'b1;
                        rd_cfr_pend <= 1'b0;
                    end else begin
                        if (sclk_fall) begin
                            sdo    <= tx_reg[FRAME_W-1];
                            tx_reg <= {tx_reg[FRAME_W-2:0], 1'b0};
                        end
                        if (sclk_rise) begin
                            rx_reg  <= {rx_reg[FRAME_W-2:0], sdi_q};
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd15) begin
                                state <= DECODE;
                            end
                        end
                    end
                end

                DECODE: begin
                    state <= IDLE;
                    if (is_select(cmd)) begin
                        channel <= cmd[CH_W-1:0];
                    end else if (cmd == CMD_RD_CFR) begin
                        rd_cfr_pend <= 1'b1;
                    end else if (cmd == CMD_WR_CFR) begin
                        cfr <= rx_reg[CFR_W-1:0];
                    end
                end

                default: state <= IDLE;
            endcase

            // ---- conversion timer ----
            if (start_conv) begin
                busy     <= 1'b1;
                conv_cnt <= 8'(CONV_CLKS - 1);
                conv_ch  <= conv_ch_next;
            end else if (busy) begin
                if (conv_cnt == 8'd0) begin
                    busy      <= 1'b0;
                    result    <= {conv_ch, samp_cnt};
                    samp_cnt  <= samp_cnt + 11'd1;
                    done_pend <= 1'b1;
                end else begin
                    conv_cnt <= conv_cnt - 8'd1;
                end
            end

            // End-of-conversion flag goes low one clk after busy drops.
            if (done_pend) begin
                int_l     <= 1'b0;
                done_pend <= 1'b0;
            end
        end
    end

    assign bus.sdo   = sdo;
    assign bus.int_l = int_l;
    assign bus.busy  = busy;
    assign bus.cfr   = cfr;

endmodule

// File: tb/tb_tlc3548_emu.sv
// Self-checking bench for tlc3548_emu: a host driver plays directed frames,
// an sdo monitor rebuilds each 16-bit frame and compares it against the
// expected-word queue filled by the stimulus.
`timescale 1ns/1ps
module tb_tlc3548_emu;

    logic clk;
    logic rst;

    tlc3548_emu_if bus ();

    tlc3548_emu #(.CONV_CLKS(40)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Host frame: fs high for the first sclk falling edge; cstart pulse can
    // be injected during the low phase of bit cst_bit.
    task automatic send_frame(input logic [15:0] word, input int nbits, input int cst_bit);
        bus.cs_l = 1'b0;
        bus.fs   = 1'b1;
        wait_clks(8);
        for (int i = 0; i < nbits; i++) begin
            bus.sdi  = word[15-i];
            bus.sclk = 1'b0;
            if (i == cst_bit) begin
                wait_clks(2);
                bus.cstart = 1'b0;
                wait_clks(2);
                bus.cstart = 1'b1;
                wait_clks(4);
            end else begin
                wait_clks(8);
            end
            bus.fs   = 1'b0;
            bus.sclk = 1'b1;
            wait_clks(8);
        end
        if (nbits == 16) wait_clks(4);
        bus.cs_l = 1'b1;
        wait_clks(8);
    endtask

    task automatic frame(input logic [15:0] word, input logic [15:0] exp_sdo, input int cst_bit);
        exp_q.push_back(exp_sdo);
        send_frame(word, 16, cst_bit);
    endtask

    task automatic cstart_pulse();
        bus.cstart = 1'b0;
        wait_clks(2);
        bus.cstart = 1'b1;
    endtask

    // Length of the next busy pulse in clk cycles, -1 if it never comes.
    task automatic measure_busy(output int len);
        int t;
        t = 0;
        while (!bus.busy && t < 800) begin
            @(negedge clk);
            t++;
        end
        if (!bus.busy) begin
            len = -1;
        end else begin
            len = 0;
            while (bus.busy && len < 1000) begin
                @(negedge clk);
                len++;
            end
        end
    endtask

    // sdo monitor: shifts in sdo on each sclk rise of a selected frame.
    initial begin
        logic [15:0] mon_word;
        int          mon_cnt;
        mon_word = '0;
        mon_cnt  = 0;
        forever begin
            @(negedge bus.sclk or posedge bus.sclk or posedge bus.cs_l);
            if (bus.cs_l) begin
                mon_cnt = 0;
            end else if (!bus.sclk) begin
                if (bus.fs) mon_cnt = 0;
            end else begin
                mon_word = {mon_word[14:0], bus.sdo};
                mon_cnt++;
                if (mon_cnt == 16) begin
                    if (exp_q.size() == 0) begin
                        check("sdo_frame_unexpected", 32'(mon_word), 32'hxxxx_xxxx);
                    end else begin
                        check("sdo_frame", 32'(mon_word), 32'(exp_q.pop_front()));
                    end
                    mon_cnt = 0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  len;
        int  t;
        logic seen_low;

        rst        = 1'b0;
        bus.cs_l   = 1'b1;
        bus.fs     = 1'b0;
        bus.sclk   = 1'b1;
        bus.sdi    = 1'b0;
        bus.cstart = 1'b1;
        wait_clks(5);
        check("reset_sdo",   32'(bus.sdo),   32'h0);
        check("reset_int_l", 32'(bus.int_l), 32'h1);
        check("reset_busy",  32'(bus.busy),  32'h0);
        check("reset_cfr",   32'(bus.cfr),   32'h0);
        rst = 1'b1;
        wait_clks(5);

        // Select ch3 -> conversion of 40 clk, then int_l low.
        fork
            frame(16'h3000, 16'h0000, -1);
            measure_busy(len);
        join
        check("ch3_busy_len", 32'(len), 32'd40);
        wait_clks(2);
        check("ch3_int_low", 32'(bus.int_l), 32'h0);
        frame(16'hF000, 16'h6000, -1);
        check("int_l_back_high", 32'(bus.int_l), 32'h1);

        // Write CFR: no conversion, int_l stays high.
        frame(16'hA940, 16'h6000, -1);
        check("wr_cfr", 32'(bus.cfr), 32'h940);
        check("wr_cfr_int_l", 32'(bus.int_l), 32'h1);
        check("wr_cfr_busy", 32'(bus.busy), 32'h0);

        // Read CFR appears in the following frame only.
        frame(16'h9000, 16'h6000, -1);
        frame(16'hF000, 16'h0940, -1);
        frame(16'hF000, 16'h6000, -1);

        // Aborted write leaves cfr alone; next full frame decodes.
        send_frame(16'hA123, 7, -1);
        check("abort_cfr", 32'(bus.cfr), 32'h940);
        frame(16'hA555, 16'h6000, -1);
        check("after_abort_cfr", 32'(bus.cfr), 32'h555);

        // Fresh reset, select ch5 (sample 0), then cstart on ch5 (sample 1).
        rst = 1'b0;
        wait_clks(3);
        check("reset2_cfr",   32'(bus.cfr),   32'h0);
        check("reset2_int_l", 32'(bus.int_l), 32'h1);
        rst = 1'b1;
        wait_clks(3);
        frame(16'h5000, 16'h0000, -1);
        wait_clks(60);
        check("ch5_int_low", 32'(bus.int_l), 32'h0);
        fork
            begin
                cstart_pulse();
                wait_clks(15);
                cstart_pulse();  // while busy: ignored
            end
            measure_busy(len);
        join
        check("cstart_busy_len", 32'(len), 32'd40);
        wait_clks(4);
        frame(16'hF000, 16'hA004, -1);
        cstart_pulse();
        measure_busy(len);
        wait_clks(2);
        frame(16'hF000, 16'hA008, -1);

        // Select ch2 during a running conversion: no restart, channel moves.
        fork
            frame(16'h2000, 16'hA008, 14);
            measure_busy(len);
        join
        check("sel_while_busy_len", 32'(len), 32'd40);
        wait_clks(4);
        cstart_pulse();
        measure_busy(len);
        check("ch2_busy_len", 32'(len), 32'd40);
        wait_clks(2);
        frame(16'hF000, 16'h4010, -1);

        // Reset in the middle of a conversion.
        frame(16'hA7FF, 16'h4010, -1);
        check("cfr_7ff", 32'(bus.cfr), 32'h7FF);
        cstart_pulse();
        t = 0;
        while (!bus.busy && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("midconv_busy_started", 32'(bus.busy), 32'h1);
        wait_clks(19);
        rst = 1'b0;
        #1;
        check("midconv_rst_int_l", 32'(bus.int_l), 32'h1);
        check("midconv_rst_busy",  32'(bus.busy),  32'h0);
        check("midconv_rst_cfr",   32'(bus.cfr),   32'h0);
        check("midconv_rst_sdo",   32'(bus.sdo),   32'h0);
        wait_clks(3);
        rst = 1'b1;
        seen_low = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!bus.int_l || bus.busy) seen_low = 1'b1;
        end
        check("no_int_after_rst", 32'(seen_low), 32'h0);
        frame(16'hF000, 16'h0000, -1);

        wait_clks(20);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
